// File: rtl/nanorv32_ahb_arbiter_if.sv
// nanorv32_ahb_arbiter_if: bus bundle for the two-master AHB-lite arbiter.
// Carries the I-side and D-side master buses and the shared slave bus.
// modport slave  : the arbiter's view (accepts master requests, drives the slave).
// modport master : the environment's view (masters plus the shared slave).
interface nanorv32_ahb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // I-side master bus
    logic [AW-1:0] haddri;
    logic          htransi;
    logic [2:0]    hsizei;
    logic [3:0]    hproti;
    logic          hwritei;
    logic [DW-1:0] hwdatai;
    logic [DW-1:0] hrdatai;
    logic          hreadyi;
    logic          hrespi;
    // D-side master bus
    logic [AW-1:0] haddrd;
    logic          htransd;
    logic [2:0]    hsized;
    logic [3:0]    hprotd;
    logic          hwrited;
    logic [DW-1:0] hwdatad;
    logic [DW-1:0] hrdatad;
    logic          hreadyd;
    logic          hrespd;
    // shared slave bus
    logic [AW-1:0] haddrs;
    logic          htranss;
    logic [2:0]    hsizes;
    logic [3:0]    hprots;
    logic          hwrites;
    logic [DW-1:0] hwdatas;
    logic          hmasters;
    logic [DW-1:0] hrdatas;
    logic          hreadys;
    logic          hresps;

    modport slave (
        input  haddri, htransi, hsizei, hproti, hwritei, hwdatai,
        output hrdatai, hreadyi, hrespi,
        input  haddrd, htransd, hsized, hprotd, hwrited, hwdatad,
        output hrdatad, hreadyd, hrespd,
        output haddrs, htranss, hsizes, hprots, hwrites, hwdatas, hmasters,
        input  hrdatas, hreadys, hresps
    );

    modport master (
        output haddri, htransi, hsizei, hproti, hwritei, hwdatai,
        input  hrdatai, hreadyi, hrespi,
        output haddrd, htransd, hsized, hprotd, hwrited, hwdatad,
        input  hrdatad, hreadyd, hrespd,
        input  haddrs, htranss, hsizes, hprots, hwrites, hwdatas, hmasters,
        output hrdatas, hreadys, hresps
    );
endinterface

// File: rtl/nanorv32_ahb_arbiter.sv
// nanorv32_ahb_arbiter: shares one AHB-lite slave between the I-side prefetch
// port and the D-side load/store port. Each master's address phase lands in a
// one-entry buffer, is issued on the next hreadys edge, and the data phase is
// routed back by the registered data-phase owner.
// Optional feature: NANORV32_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// between simultaneous requests; undefined gives D-side fixed priority.
module nanorv32_ahb_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nanorv32_ahb_arbiter_if.slave   bus
);

    // request buffers
    logic          pend_i_r;
    logic          pend_d_r;
    logic [AW-1:0] addr_i_r;
    logic [AW-1:0] addr_d_r;
    logic [2:0]    size_i_r;
    logic [2:0]    size_d_r;
    logic [3:0]    prot_i_r;
    logic [3:0]    prot_d_r;
    logic          write_i_r;
    logic          write_d_r;

    // slave address phase (htranss_r doubles as aph_valid, hmasters_r as aph_owner)
    logic [AW-1:0] haddrs_r;
    logic          htranss_r;
    logic [2:0]    hsizes_r;
    logic [3:0]    hprots_r;
    logic          hwrites_r;
    logic          hmasters_r;

    // slave data phase
    logic          dph_valid_r;
    logic          dph_owner_r;

`ifdef NANORV32_ARB_ROUND_ROBIN_EN
    logic          last_grant_r;
`endif

    logic          busy_i_s;
    logic          busy_d_s;
    logic          hready_i_s;
    logic          hready_d_s;
    logic          cap_i_s;
    logic          cap_d_s;
    logic          grant_d_s;
    logic          pend_any_s;

    // per-master busy/ready; the completing data-phase cycle reopens the port
    always_comb begin
        busy_i_s   = pend_i_r | (htranss_r & ~hmasters_r) | (dph_valid_r & ~dph_owner_r);
        busy_d_s   = pend_d_r | (htranss_r & hmasters_r) | (dph_valid_r & dph_owner_r);
        hready_i_s = ~busy_i_s | (dph_valid_r & ~dph_owner_r & bus.hreadys);
        hready_d_s = ~busy_d_s | (dph_valid_r & dph_owner_r & bus.hreadys);
        cap_i_s    = bus.htransi & hready_i_s;
        cap_d_s    = bus.htransd & hready_d_s;
        pend_any_s = pend_i_r | pend_d_r;
    end

    // pick the winner among the buffered requests (1 = D-side)
    always_comb begin
        grant_d_s = 1'b0;
`ifdef NANORV32_ARB_ROUND_ROBIN_EN
        if (pend_i_r && pend_d_r) begin
            grant_d_s = ~last_grant_r;
        end else begin
            grant_d_s = pend_d_r;
        end
`else
        grant_d_s = pend_d_r;
`endif
    end

    // request capture, slave address phase sequencing and data-phase tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_i_r    <= 1'b0;
            pend_d_r    <= 1'b0;
            addr_i_r    <= {AW{1'b0}};
            addr_d_r    <= {AW{1'b0}};
            size_i_r    <= 3'd0;
            size_d_r    <= 3'd0;
            prot_i_r    <= 4'd0;
            prot_d_r    <= 4'd0;
            write_i_r   <= 1'b0;
            write_d_r   <= 1'b0;
            haddrs_r    <= {AW{1'b0}};
            htranss_r   <= 1'b0;
            hsizes_r    <= 3'd0;
            hprots_r    <= 4'd0;
            hwrites_r   <= 1'b0;
            hmasters_r  <= 1'b0;
            dph_valid_r <= 1'b0;
            dph_owner_r <= 1'b0;
`ifdef NANORV32_ARB_ROUND_ROBIN_EN
            last_grant_r <= 1'b0;
`endif
        end else begin
            // a master can never be captured and granted on the same edge:
            // capture needs hready high, which a pending master never has
            if (cap_i_s) begin
                pend_i_r  <= 1'b1;
                addr_i_r  <= bus.haddri;
                size_i_r  <= bus.hsizei;
                prot_i_r  <= bus.hproti;
                write_i_r <= bus.hwritei;
            end else if (bus.hreadys && pend_i_r && !grant_d_s) begin
                pend_i_r  <= 1'b0;
            end

            if (cap_d_s) begin
                pend_d_r  <= 1'b1;
                addr_d_r  <= bus.haddrd;
                size_d_r  <= bus.hsized;
                prot_d_r  <= bus.hprotd;
                write_d_r <= bus.hwrited;
            end else if (bus.hreadys && pend_d_r && grant_d_s) begin
                pend_d_r  <= 1'b0;
            end

            // slave address phase only advances when the slave is ready
            if (bus.hreadys) begin
                dph_valid_r <= htranss_r;
                dph_owner_r <= hmasters_r;
                if (pend_any_s) begin
                    htranss_r  <= 1'b1;
                    hmasters_r <= grant_d_s;
                    haddrs_r   <= grant_d_s ? addr_d_r  : addr_i_r;
                    hsizes_r   <= grant_d_s ? size_d_r  : size_i_r;
                    hprots_r   <= grant_d_s ? prot_d_r  : prot_i_r;
                    hwrites_r  <= grant_d_s ? write_d_r : write_i_r;
`ifdef NANORV32_ARB_ROUND_ROBIN_EN
                    last_grant_r <= grant_d_s;
`endif
                end else begin
                    htranss_r  <= 1'b0;
                end
            end
        end
    end

    // address phase and response routing
    assign bus.haddrs   = haddrs_r;
    assign bus.htranss  = htranss_r;
    assign bus.hsizes   = hsizes_r;
    assign bus.hprots   = hprots_r;
    assign bus.hwrites  = hwrites_r;
    assign bus.hmasters = hmasters_r;
    assign bus.hwdatas  = dph_owner_r ? bus.hwdatad : bus.hwdatai;
    assign bus.hrdatai  = bus.hrdatas;
    assign bus.hrdatad  = bus.hrdatas;
    assign bus.hreadyi  = hready_i_s;
    assign bus.hreadyd  = hready_d_s;
    assign bus.hrespi   = bus.hresps & dph_valid_r & ~dph_owner_r;
    assign bus.hrespd   = bus.hresps & dph_valid_r & dph_owner_r;

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// tb_nanorv32_ahb_arbiter: directed-vector bench for nanorv32_ahb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_nanorv32_ahb_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    nanorv32_ahb_arbiter_if #(.AW(32), .DW(32)) bus ();

    nanorv32_ahb_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus.haddri   = 32'd0; bus.htransi = 1'b0; bus.hsizei = 3'd2; bus.hproti = 4'd0;
        bus.hwritei  = 1'b0;  bus.hwdatai = 32'd0;
        bus.haddrd   = 32'd0; bus.htransd = 1'b0; bus.hsized = 3'd2; bus.hprotd = 4'd1;
        bus.hwrited  = 1'b0;  bus.hwdatad = 32'd0;
        bus.hrdatas  = 32'd0; bus.hreadys = 1'b1; bus.hresps = 1'b0;

        // reset state
        cyc(); cyc(); #1;
        check("rst_hreadyi", 32'(bus.hreadyi), 32'd1);
        check("rst_hreadyd", 32'(bus.hreadyd), 32'd1);
        check("rst_hrespi",  32'(bus.hrespi),  32'd0);
        check("rst_hrespd",  32'(bus.hrespd),  32'd0);
        check("rst_htranss", 32'(bus.htranss), 32'd0);
        check("rst_haddrs",  bus.haddrs,       32'd0);
        check("rst_hmasters", 32'(bus.hmasters), 32'd0);
        cyc(); rst_n = 1'b1;

        // 1: single I read, zero-wait slave
        cyc(); bus.htransi = 1'b1; bus.haddri = 32'h0000_0100; #1;
        check("t1_c0_hreadyi", 32'(bus.hreadyi), 32'd1);
        cyc(); bus.htransi = 1'b0; #1;
        check("t1_c1_htranss", 32'(bus.htranss), 32'd0);
        check("t1_c1_hreadyi", 32'(bus.hreadyi), 32'd0);
        cyc(); #1;
        check("t1_c2_htranss", 32'(bus.htranss), 32'd1);
        check("t1_c2_haddrs",  bus.haddrs,       32'h0000_0100);
        check("t1_c2_hmasters", 32'(bus.hmasters), 32'd0);
        check("t1_c2_hsizes",  32'(bus.hsizes),  32'd2);
        check("t1_c2_hreadyd", 32'(bus.hreadyd), 32'd1);
        cyc(); bus.hrdatas = 32'h1234_5678; #1;
        check("t1_c3_hreadyi", 32'(bus.hreadyi), 32'd1);
        check("t1_c3_hrdatai", bus.hrdatai,      32'h1234_5678);
        check("t1_c3_hreadyd", 32'(bus.hreadyd), 32'd1);
        check("t1_c3_htranss", 32'(bus.htranss), 32'd0);

        // 2: simultaneous I read and D write, D issues first
        cyc(); bus.htransi = 1'b1; bus.haddri = 32'h0000_0200;
        bus.htransd = 1'b1; bus.haddrd = 32'h8000_0004; bus.hwrited = 1'b1; #1;
        check("t2_c0_hreadyi", 32'(bus.hreadyi), 32'd1);
        check("t2_c0_hreadyd", 32'(bus.hreadyd), 32'd1);
        cyc(); bus.htransi = 1'b0; bus.htransd = 1'b0; bus.hwrited = 1'b0;
        bus.hwdatad = 32'hCAFE_F00D; bus.hwdatai = 32'h1111_2222; #1;
        check("t2_c1_hreadyi", 32'(bus.hreadyi), 32'd0);
        check("t2_c1_hreadyd", 32'(bus.hreadyd), 32'd0);
        cyc(); #1;
        check("t2_c2_haddrs",  bus.haddrs,         32'h8000_0004);
        check("t2_c2_hmasters", 32'(bus.hmasters), 32'd1);
        check("t2_c2_hwrites", 32'(bus.hwrites),   32'd1);
        check("t2_c2_hprots",  32'(bus.hprots),    32'd1);
        check("t2_c2_htranss", 32'(bus.htranss),   32'd1);
        cyc(); #1;
        check("t2_c3_haddrs",  bus.haddrs,         32'h0000_0200);
        check("t2_c3_hmasters", 32'(bus.hmasters), 32'd0);
        check("t2_c3_hwrites", 32'(bus.hwrites),   32'd0);
        check("t2_c3_hwdatas", bus.hwdatas,        32'hCAFE_F00D);
        check("t2_c3_hreadyd", 32'(bus.hreadyd),   32'd1);
        check("t2_c3_hreadyi", 32'(bus.hreadyi),   32'd0);
        cyc(); bus.hrdatas = 32'hAAAA_5555; #1;
        check("t2_c4_hreadyi", 32'(bus.hreadyi), 32'd1);
        check("t2_c4_hrdatai", bus.hrdatai,      32'hAAAA_5555);
        check("t2_c4_hwdatas", bus.hwdatas,      32'h1111_2222);

        // 3: D read with two slave wait states, I request pending behind it
        cyc(); bus.htransd = 1'b1; bus.haddrd = 32'h0000_0300; #1;
        cyc(); bus.htransd = 1'b0; #1;
        cyc(); bus.htransi = 1'b1; bus.haddri = 32'h0000_0400; #1;
        check("t3_c2_haddrs",  bus.haddrs,       32'h0000_0300);
        check("t3_c2_hreadyi", 32'(bus.hreadyi), 32'd1);
        for (int w = 0; w < 2; w++) begin
            cyc(); bus.htransi = 1'b0; bus.hreadys = 1'b0; #1;
            check("t3_wait_hreadyd", 32'(bus.hreadyd), 32'd0);
            check("t3_wait_hreadyi", 32'(bus.hreadyi), 32'd0);
            check("t3_wait_htranss", 32'(bus.htranss), 32'd0);
            check("t3_wait_haddrs",  bus.haddrs,       32'h0000_0300);
        end
        cyc(); bus.hreadys = 1'b1; bus.hrdatas = 32'h0000_D00D; #1;
        check("t3_done_hreadyd", 32'(bus.hreadyd), 32'd1);
        check("t3_done_hrdatad", bus.hrdatad,      32'h0000_D00D);
        check("t3_done_htranss", 32'(bus.htranss), 32'd0);
        cyc(); #1;
        check("t3_i_htranss", 32'(bus.htranss),   32'd1);
        check("t3_i_haddrs",  bus.haddrs,         32'h0000_0400);
        check("t3_i_hmasters", 32'(bus.hmasters), 32'd0);
        cyc(); #1;
        check("t3_i_hreadyi", 32'(bus.hreadyi), 32'd1);

        // 4: I streams back-to-back reads 0x0, 0x4, 0x8
        for (int k = 0; k < 3; k++) begin
            cyc(); bus.htransi = 1'b1; bus.haddri = 32'(k * 4);
            bus.hrdatas = 32'h1000_0000 + 32'(k); #1;
            check("t4_accept_hreadyi", 32'(bus.hreadyi), 32'd1);
            if (k > 0) begin
                check("t4_hrdatai", bus.hrdatai, 32'h1000_0000 + 32'(k));
            end
            cyc(); bus.htransi = 1'b0; #1;
            check("t4_pend_hreadyi", 32'(bus.hreadyi), 32'd0);
            cyc(); #1;
            check("t4_haddrs",   bus.haddrs,         32'(k * 4));
            check("t4_htranss",  32'(bus.htranss),   32'd1);
            check("t4_hmasters", 32'(bus.hmasters),  32'd0);
        end
        cyc(); #1;
        check("t4_last_hreadyi", 32'(bus.hreadyi), 32'd1);

        // 5: error response on a D data phase
        cyc(); bus.htransd = 1'b1; bus.haddrd = 32'h0000_0500; #1;
        cyc(); bus.htransd = 1'b0; #1;
        cyc(); #1;
        cyc(); bus.hresps = 1'b1; #1;
        check("t5_hrespd",  32'(bus.hrespd),  32'd1);
        check("t5_hreadyd", 32'(bus.hreadyd), 32'd1);
        check("t5_hrespi",  32'(bus.hrespi),  32'd0);
        cyc(); bus.hresps = 1'b0; #1;
        check("t5_after_hrespd", 32'(bus.hrespd), 32'd0);

        // 6: reset with I pending and D in its data phase
        cyc(); bus.htransd = 1'b1; bus.haddrd = 32'h0000_0600; #1;
        cyc(); bus.htransd = 1'b0; #1;
        cyc(); bus.htransi = 1'b1; bus.haddri = 32'h0000_0700; #1;
        cyc(); bus.htransi = 1'b0; bus.hreadys = 1'b0; #1;
        check("t6_pre_hreadyi", 32'(bus.hreadyi), 32'd0);
        check("t6_pre_hreadyd", 32'(bus.hreadyd), 32'd0);
        rst_n = 1'b0; #1;
        check("t6_rst_hreadyi",  32'(bus.hreadyi),  32'd1);
        check("t6_rst_hreadyd",  32'(bus.hreadyd),  32'd1);
        check("t6_rst_htranss",  32'(bus.htranss),  32'd0);
        check("t6_rst_haddrs",   bus.haddrs,        32'd0);
        check("t6_rst_hmasters", 32'(bus.hmasters), 32'd0);
        cyc(); rst_n = 1'b1; bus.hreadys = 1'b1; #1;
        cyc(); bus.htransi = 1'b1; bus.haddri = 32'h0000_0040; #1;
        check("t6_c0_hreadyi", 32'(bus.hreadyi), 32'd1);
        cyc(); bus.htransi = 1'b0; #1;
        check("t6_c1_htranss", 32'(bus.htranss), 32'd0);
        cyc(); #1;
        check("t6_c2_htranss", 32'(bus.htranss), 32'd1);
        check("t6_c2_haddrs",  bus.haddrs,       32'h0000_0040);
        cyc(); bus.hrdatas = 32'h0000_4040; #1;
        check("t6_c3_hreadyi", 32'(bus.hreadyi), 32'd1);
        check("t6_c3_hrdatai", bus.hrdatai,      32'h0000_4040);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nanorv32_ahb_arbiter.md
Name: nanorv32_ahb_arbiter

Overview:
- Two-master AHB-lite arbiter that lets the instruction prefetch port (I-side) and the load/store port (D-side) share one single-ported AHB-lite slave, such as a unified code/data SRAM.
- Each master's address phase is captured into a one-entry request buffer. The buffered request is then sequenced onto the slave port.
- The arbiter drives per-master hready/hresp so that the prefetch buffer and the LSU see ordinary AHB-lite wait states.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk in 1: clock (single clock domain).
- rst_n in 1: asynchronous active-low reset.
- haddri in AW: I-side address.
- htransi in 1: I-side transfer request (1 = NONSEQ, 0 = IDLE).
- hsizei in 3: I-side size.
- hproti in 4: I-side protection.
- hwritei in 1: I-side write.
- hwdatai in DW: I-side write data.
- hrdatai out DW: I-side read data.
- hreadyi out 1: I-side ready.
- hrespi out 1: I-side error.
- haddrd, htransd, hsized, hprotd, hwrited, hwdatad in (same widths): D-side request.
- hrdatad out DW, hreadyd out 1, hrespd out 1: D-side response.
- haddrs out AW, htranss out 1, hsizes out 3, hprots out 4, hwrites out 1, hwdatas out DW: slave address/write-data phase.
- hmasters out 1: owner of the slave address phase (0 = I, 1 = D).
- hrdatas in DW, hreadys in 1, hresps in 1: slave response.

Behaviour:
- Reset values:
  - hreadyi = hreadyd = 1.
  - hrespi = hrespd = 0.
  - htranss = 0, haddrs = 0, hsizes = 0, hprots = 0, hwrites = 0, hmasters = 0.
  - Internal: pend_i = pend_d = 0, aph_valid = 0, dph_valid = 0, last_grant = I.
- Per-master state, derived from pend_m, aph ownership and dph ownership:
  - IDLE → PEND: htrans_m & hready_m. Capture addr/size/prot/write into the buffer and set pend_m.
  - PEND → APH: granted. Buffer is copied into the slave address registers and pend_m clears.
  - APH → DPH: hreadys = 1.
  - DPH → IDLE: hreadys = 1 while dph_owner = m.
- hready_m = ~busy_m | (dph_valid & dph_owner == m & hreadys), where busy_m = pend_m | (aph_valid & aph_owner == m) | (dph_valid & dph_owner == m).
  - The completing cycle also accepts m's next address phase; a back-to-back request enters PEND in that same edge.
- Slave address registers (haddrs…hmasters, htranss):
  - Updated only when hreadys = 1; held stable while hreadys = 0.
  - On an update, load the winner among pend_i/pend_d with htranss = 1, or load htranss = 0 if none is pending.
  - On the same edge, dph_valid <= aph_valid and dph_owner <= aph_owner.
- Arbitration (default): D-side fixed priority. Starvation of I is impossible because D holds at most one outstanding transfer and cannot re-request until its data phase completes.
- Data phase routing:
  - hwdatas = hwdata of dph_owner. The master holds it, since its hready is low until completion.
  - hrdatai = hrdatad = hrdatas, unconditionally.
  - hresp_m = hresps & dph_valid & (dph_owner == m). A single-cycle error ends the data phase like OKAY.
- Latency (zero-wait slave), request seen at cycle 0:
  - Cycle 1: PEND.
  - Cycle 2: slave address phase.
  - Cycle 3: slave data phase; hready_m = 1 with data.
  - Two arbiter wait states per transfer; slave wait states add 1:1.
- Simultaneous requests: both are captured in the same cycle. The winner issues first; the loser issues on the next hreadys = 1 edge.
- A request presented while hready_m = 0 is ignored; the master holds it per AHB-lite.
- htrans_m with an outstanding transfer and hready_m = 1 (the completing cycle) is legal and is captured.
- Reset mid-transfer: all state clears immediately and the slave sees htranss = 0. The slave data phase in flight is abandoned; the system resets the slave in the same domain.

Optional Feature:
- NANORV32_ARB_ROUND_ROBIN_EN defined:
  - When both masters are pending, the master not equal to last_grant wins.
  - last_grant updates on every grant.
  - A single pending master always wins.
- Undefined: D-side fixed priority; last_grant is not implemented.

Test Plan:
1. I read 0x0000_0100, slave returns 0x1234_5678 with zero wait → htranss = 1/haddrs = 0x100/hmasters = 0 in cycle 2, hreadyi = 1 and hrdatai = 0x1234_5678 in cycle 3, hreadyd = 1 throughout.
2. I read 0x200 and D write 0x8000_0004 (data 0xCAFE_F00D) in the same cycle → D issues in cycle 2 and I in cycle 3. hwdatas = 0xCAFE_F00D in cycle 3. hreadyd = 1 in cycle 3, hreadyi = 1 in cycle 4. With ROUND_ROBIN_EN and last_grant = D, I issues first.
3. Slave inserts 2 wait states on a D read → haddrs/htranss stable during the waits, hreadyd = 0 for 2 extra cycles, and a pending I request is not issued until the hreadys = 1 edge.
4. I streams back-to-back reads 0x0, 0x4, 0x8 → each new address is captured on the cycle hreadyi = 1, and slave addresses 0x0, 0x4, 0x8 appear every 3 cycles with no I/D mix-up.
5. Slave hresps = 1 on a D data phase → hrespd = 1 and hreadyd = 1 for one cycle, hrespi = 0.
6. rst_n asserted while I is in PEND and D is in DPH → hreadyi = hreadyd = 1 and htranss = 0 immediately; after release, a new I read at 0x40 completes with the normal 3-cycle latency.
